serial_word_shifter: RTL

//   Parallel-to-serial stage feeding the bit-sequence detector's data_in input.
//   - Accepts an NBITS word through a load/ready handshake.
//   - Presents the word one bit per clk_2 cycle, LSB first, on serial_out.
//   - Pulses done when the word is finished.
//   - Lets the detector be driven with known patterns instead of hand-toggled switches.

---
 rtl/serial_word_shifter_if.sv | 25 ++
 rtl/serial_word_shifter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/serial_word_shifter_if.sv
// Handshake and serial-stream bundle between a word source and serial_word_shifter.
// The master loads words; the slave (the shifter) presents them bit by bit.
interface serial_word_shifter_if #(
  parameter int NBITS = 8
);
  localparam int IW = $clog2(NBITS + 1);

  logic [NBITS-1:0] din;
  logic             load;
  logic             ready;
  logic             serial_out;
  logic             bit_valid;
  logic [IW-1:0]    bit_idx;
  logic             done;

  modport master (
    output din, load,
    input  ready, serial_out, bit_valid, bit_idx, done
  );

  modport slave (
    input  din, load,
    output ready, serial_out, bit_valid, bit_idx, done
  );
endinterface

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial stage: takes an NBITS word on load/ready and shifts it out LSB first.
// Optional even-parity trailer bit when SERIAL_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for load; ready=1; done pulses here for one cycle after a word
// SHIFT  | data bits 0..NBITS-1 on serial_out
// PARITY | parity bit on serial_out (SERIAL_PARITY_EN only)
module serial_word_shifter #(
  parameter int NBITS      = 8,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                 clk_2,
  input  logic                 reset,
  serial_word_shifter_if.slave bus
);
  localparam int              IW       = $clog2(NBITS + 1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NBITS - 1);

`ifdef SERIAL_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [NBITS-1:0] shreg, shreg_nxt;
  logic             serial_q, serial_nxt;
  logic             valid_q, valid_nxt;
  logic [IW-1:0]    idx_q, idx_nxt;
  logic             done_q, done_nxt;
`ifdef SERIAL_PARITY_EN
  logic             parity_q, parity_nxt;
`endif

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      serial_q <= IDLE_LEVEL;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      serial_q <= serial_nxt;
      valid_q  <= valid_nxt;
      idx_q    <= idx_nxt;
      done_q   <= done_nxt;
`ifdef SERIAL_PARITY_EN
      parity_q <= parity_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    serial_nxt = serial_q;
    valid_nxt  = valid_q;
    idx_nxt    = idx_q;
    done_nxt   = 1'b0;
`ifdef SERIAL_PARITY_EN
    parity_nxt = parity_q;
`endif
    case (state)
      IDLE: begin
        if (bus.load) begin
          serial_nxt = bus.din[0];
          valid_nxt  = 1'b1;
          idx_nxt    = '0;
          shreg_nxt  = bus.din >> 1;
          state_nxt  = SHIFT;
`ifdef SERIAL_PARITY_EN
          parity_nxt = ^bus.din;
`endif
        end
      end
      SHIFT: begin
        if (idx_q != LAST_IDX) begin
          serial_nxt = shreg[0];
          shreg_nxt  = shreg >> 1;
          idx_nxt    = idx_q + 1'b1;
        end else begin
`ifdef SERIAL_PARITY_EN
          serial_nxt = parity_q;
          valid_nxt  = 1'b1;
          idx_nxt    = IW'(NBITS);
          state_nxt  = PARITY;
`else
          serial_nxt = IDLE_LEVEL;
          valid_nxt  = 1'b0;
          idx_nxt    = '0;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        serial_nxt = IDLE_LEVEL;
        valid_nxt  = 1'b0;
        idx_nxt    = '0;
        done_nxt   = 1'b1;
        state_nxt  = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ready is the only combinational output so a load in the done cycle is accepted
  assign bus.ready      = (state == IDLE);
  assign bus.serial_out = serial_q;
  assign bus.bit_valid  = valid_q;
  assign bus.bit_idx    = idx_q;
  assign bus.done       = done_q;
endmodule
